// File: rtl/shift_reg_sched.sv
// shift_reg_sched: sequences one shared 4-mode universal shift register between a
// parallel-to-serial TX requester and a serial-to-parallel RX requester (RX has priority).
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   tx_valid/tx_ready/tx_data    TX word handshake
//   rx_req, rx_bit_en, rx_bit    RX frame request and serial bit stream
//   rx_valid, rx_data            one-cycle received-word pulse
//   ser_out, ser_out_en          serial transmit bit and its qualifier
//   busy                         controller is not idle
//   sr_mode, sr_par, sr_ser_in   controls to the shift register
//   sr_q                         shift register contents read back
module shift_reg_sched #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             rx_req,
  input  logic             rx_bit_en,
  input  logic             rx_bit,
  output logic             rx_valid,
  output logic [WIDTH-1:0] rx_data,
  output logic             ser_out,
  output logic             ser_out_en,
  output logic             busy,
  output logic [1:0]       sr_mode,
  output logic [WIDTH-1:0] sr_par,
  output logic             sr_ser_in,
  input  logic [WIDTH-1:0] sr_q
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_SHR   = 2'b01;
  localparam logic [1:0] MODE_SHL   = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;
  // Frame order picks the shift direction: LSB-first leaves through q[0].
  localparam logic [1:0] MODE_SHIFT = LSB_FIRST ? MODE_SHR : MODE_SHL;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    TX_LOAD  = 3'd1,
    TX_SHIFT = 3'd2,
    RX_SHIFT = 3'd3,
    RX_DONE  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] word_q, word_d;

  // State, bit counter and latched TX word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
    end
  end

  // Next-state and register control.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
    tx_ready   = 1'b0;
    rx_valid   = 1'b0;
    rx_data    = '0;
    ser_out    = 1'b0;
    ser_out_en = 1'b0;
    busy       = (state_q != IDLE);
    sr_mode    = MODE_HOLD;
    sr_par     = '0;
    sr_ser_in  = 1'b0;

    case (state_q)
      IDLE: begin
        tx_ready = ~rx_req;
        if (rx_req) begin
          state_d = RX_SHIFT;
          cnt_d   = '0;
        end else if (tx_valid) begin
          word_d  = tx_data;
          state_d = TX_LOAD;
        end
      end
      TX_LOAD: begin
        sr_mode = MODE_LOAD;
        sr_par  = word_q;
        cnt_d   = '0;
        state_d = TX_SHIFT;
      end
      TX_SHIFT: begin
        ser_out_en = 1'b1;
        ser_out    = LSB_FIRST ? sr_q[0] : sr_q[WIDTH-1];
        sr_mode    = MODE_SHIFT;
        cnt_d      = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      RX_SHIFT: begin
        // Gaps in the bit stream simply hold the register.
        if (rx_bit_en) begin
          sr_mode   = MODE_SHIFT;
          sr_ser_in = rx_bit;
          cnt_d     = cnt_q + CW'(1);
          if (cnt_q == LAST_BIT) begin
            cnt_d   = '0;
            state_d = RX_DONE;
          end
        end
      end
      RX_DONE: begin
        rx_valid = 1'b1;
        rx_data  = sr_q;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // While reset is asserted every output is forced low.
    if (rst) begin
      tx_ready   = 1'b0;
      rx_valid   = 1'b0;
      rx_data    = '0;
      ser_out    = 1'b0;
      ser_out_en = 1'b0;
      busy       = 1'b0;
      sr_mode    = MODE_HOLD;
      sr_par     = '0;
      sr_ser_in  = 1'b0;
    end
  end

endmodule
